// File: rtl/cook_timer_pkg.sv
// Shared definitions for the cooking countdown timer: state encoding and BCD field layout.
package cook_timer_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StPause = 2'd2,
    StDone  = 2'd3
  } state_e;

  // Nibble offsets in the {min_tens, min_units, sec_tens, sec_units} bus.
  localparam int unsigned SecUnitsLsb = 0;
  localparam int unsigned SecTensLsb  = 4;
  localparam int unsigned MinUnitsLsb = 8;
  localparam int unsigned MinTensLsb  = 12;

  localparam logic [3:0] SecTensMax = 4'd5;

endpackage

// File: rtl/cook_timer_if.sv
// Control, load and display signals between the timer and its surroundings.
interface cook_timer_if;
  logic        sec_clk;
  logic        load;
  logic [15:0] ld_digits;
  logic        start;
  logic        stop;
  logic        door_open;
  logic [15:0] digits;
  logic        mag_on;
  logic        buzzer;
  logic        done;
  logic        load_err;
  logic [1:0]  state;

  modport master (
    output sec_clk, load, ld_digits, start, stop, door_open,
    input  digits, mag_on, buzzer, done, load_err, state
  );

  modport slave (
    input  sec_clk, load, ld_digits, start, stop, door_open,
    output digits, mag_on, buzzer, done, load_err, state
  );
endinterface

// File: rtl/cook_timer_bcd_dec4.sv
// Combinational MM:SS BCD decrement with zero flag, plus legality check of a load value.
module cook_timer_bcd_dec4
  import cook_timer_pkg::*;
#(
  parameter int unsigned MAX_MIN_TENS = 9
) (
  input  logic [15:0] value_i,
  input  logic [15:0] check_i,
  output logic [15:0] dec_o,
  output logic        zero_o,
  output logic        legal_o
);

  logic [3:0] su, st, mu, mt;
  logic [3:0] c_su, c_st, c_mu, c_mt;

  assign su = value_i[SecUnitsLsb +: 4];
  assign st = value_i[SecTensLsb +: 4];
  assign mu = value_i[MinUnitsLsb +: 4];
  assign mt = value_i[MinTensLsb +: 4];

  assign c_su = check_i[SecUnitsLsb +: 4];
  assign c_st = check_i[SecTensLsb +: 4];
  assign c_mu = check_i[MinUnitsLsb +: 4];
  assign c_mt = check_i[MinTensLsb +: 4];

  assign zero_o = (value_i == 16'h0000);

  assign legal_o = (c_su <= 4'd9) && (c_st <= SecTensMax) && (c_mu <= 4'd9) &&
                   (c_mt <= 4'd9) && (c_mt <= 4'(MAX_MIN_TENS));

  // A zero input passes through unchanged so the count can never wrap.
  always_comb begin
    dec_o = value_i;
    if (!zero_o) begin
      if (su != 4'd0) begin
        dec_o[SecUnitsLsb +: 4] = su - 4'd1;
      end else begin
        dec_o[SecUnitsLsb +: 4] = 4'd9;
        if (st != 4'd0) begin
          dec_o[SecTensLsb +: 4] = st - 4'd1;
        end else begin
          dec_o[SecTensLsb +: 4] = SecTensMax;
          if (mu != 4'd0) begin
            dec_o[MinUnitsLsb +: 4] = mu - 4'd1;
          end else begin
            dec_o[MinUnitsLsb +: 4] = 4'd9;
            dec_o[MinTensLsb +: 4]  = mt - 4'd1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/cook_timer.sv
// Microwave countdown timer: 1 Hz tick detect, MM:SS countdown FSM, alarm hold and outputs.
module cook_timer
  import cook_timer_pkg::*;
#(
  parameter int unsigned ALARM_SECS   = 3,
  parameter int unsigned MAX_MIN_TENS = 9
) (
  input  logic          clk_in,
  input  logic          rst_n,
  cook_timer_if.slave   bus
);

  localparam logic [3:0] AlarmLast = 4'(ALARM_SECS);

  state_e      state_q, state_d;
  logic [15:0] digits_q, digits_d;
  logic [3:0]  alarm_q, alarm_d;
  logic        done_q, done_d;
  logic        load_err_q, load_err_d;
  logic        mag_on_q, buzzer_q;
  logic        sec_prev_q;
  logic        tick;
  logic [15:0] dec;
  logic        digits_zero, dec_zero, ld_legal;

  assign tick     = bus.sec_clk & ~sec_prev_q;
  assign dec_zero = (dec == 16'h0000);

  cook_timer_bcd_dec4 #(
    .MAX_MIN_TENS(MAX_MIN_TENS)
  ) u_bcd_dec4 (
    .value_i (digits_q),
    .check_i (bus.ld_digits),
    .dec_o   (dec),
    .zero_o  (digits_zero),
    .legal_o (ld_legal)
  );

  // Strict priority: the highest active request wins, everything below it is dropped.
  always_comb begin
    state_d    = state_q;
    digits_d   = digits_q;
    alarm_d    = alarm_q;
    done_d     = 1'b0;
    load_err_d = 1'b0;
    if (bus.door_open) begin
      if (state_q == StRun) state_d = StPause;
    end else if (bus.stop) begin
      unique case (state_q)
        StIdle:  ;
        StRun:   state_d = StPause;
        StPause: begin
          state_d  = StIdle;
          digits_d = 16'h0000;
        end
        StDone:  begin
          state_d = StIdle;
          alarm_d = 4'd0;
        end
      endcase
    end else if (bus.start) begin
      if ((state_q == StIdle || state_q == StPause) && !digits_zero) begin
        state_d = StRun;
      end else if (state_q == StDone) begin
        state_d = StIdle;
        alarm_d = 4'd0;
      end
    end else if (bus.load) begin
      if (state_q != StRun) begin
        if (ld_legal) begin
          digits_d = bus.ld_digits;
          if (state_q == StDone) begin
            state_d = StIdle;
            alarm_d = 4'd0;
          end
        end else begin
          load_err_d = 1'b1;
        end
      end
    end else if (tick) begin
      if (state_q == StRun) begin
        digits_d = dec;
        if (dec_zero) begin
          state_d = StDone;
          done_d  = 1'b1;
          alarm_d = 4'd0;
        end
      end else if (state_q == StDone) begin
        if (alarm_q + 4'd1 == AlarmLast) begin
          state_d = StIdle;
          alarm_d = 4'd0;
        end else begin
          alarm_d = alarm_q + 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      digits_q   <= 16'h0000;
      alarm_q    <= 4'd0;
      done_q     <= 1'b0;
      load_err_q <= 1'b0;
      mag_on_q   <= 1'b0;
      buzzer_q   <= 1'b0;
      sec_prev_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      digits_q   <= digits_d;
      alarm_q    <= alarm_d;
      done_q     <= done_d;
      load_err_q <= load_err_d;
      mag_on_q   <= (state_d == StRun);
      buzzer_q   <= (state_d == StDone);
      sec_prev_q <= bus.sec_clk;
    end
  end

  assign bus.digits   = digits_q;
  assign bus.state    = state_q;
  assign bus.mag_on   = mag_on_q;
  assign bus.buzzer   = buzzer_q;
  assign bus.done     = done_q;
  assign bus.load_err = load_err_q;

endmodule

// File: tb/tb_cook_timer.sv
// Randomized and directed bench for cook_timer against a seconds-based reference model.
module tb_cook_timer;

  localparam int AlarmSecs = 3;
  localparam int MaxMinTens = 9;

  logic clk_in = 1'b0;
  logic rst_n  = 1'b0;
  cook_timer_if bus ();

  cook_timer #(
    .ALARM_SECS   (AlarmSecs),
    .MAX_MIN_TENS (MaxMinTens)
  ) dut (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .bus    (bus)
  );

  always #5 clk_in = ~clk_in;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc_cnt = 0;
  int per = 100;
  int sec_force = -1;
  bit rst_v = 1'b0;
  bit chk_en = 1'b1;

  // Model: remaining time kept as a plain number of seconds.
  int m_state = 0;
  int m_secs = 0;
  int m_alarm = 0;
  bit m_done = 0, m_err = 0, m_prev = 1;

  initial begin
    bus.sec_clk = 1'b0; bus.load = 1'b0; bus.ld_digits = 16'h0;
    bus.start = 1'b0; bus.stop = 1'b0; bus.door_open = 1'b0;
  end

  function automatic logic [15:0] to_bcd(input int s);
    int m, x;
    m = s / 60;
    x = s % 60;
    return {4'(m / 10), 4'(m % 10), 4'(x / 10), 4'(x % 10)};
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit tick;
    int su, st, mu, mt;
    if (!rst_n) begin
      m_state = 0; m_secs = 0; m_alarm = 0; m_done = 0; m_err = 0; m_prev = 1;
      return;
    end
    tick = bus.sec_clk && !m_prev;
    m_prev = bus.sec_clk;
    m_done = 0;
    m_err = 0;
    if (bus.door_open) begin
      if (m_state == 1) m_state = 2;
    end else if (bus.stop) begin
      if (m_state == 1) m_state = 2;
      else if (m_state == 2) begin m_state = 0; m_secs = 0; end
      else if (m_state == 3) begin m_state = 0; m_alarm = 0; end
    end else if (bus.start) begin
      if ((m_state == 0 || m_state == 2) && m_secs > 0) m_state = 1;
      else if (m_state == 3) begin m_state = 0; m_alarm = 0; end
    end else if (bus.load) begin
      if (m_state != 1) begin
        su = int'(bus.ld_digits[3:0]);  st = int'(bus.ld_digits[7:4]);
        mu = int'(bus.ld_digits[11:8]); mt = int'(bus.ld_digits[15:12]);
        if (su <= 9 && st <= 5 && mu <= 9 && mt <= MaxMinTens) begin
          m_secs = (mt * 10 + mu) * 60 + st * 10 + su;
          if (m_state == 3) begin m_state = 0; m_alarm = 0; end
        end else begin
          m_err = 1;
        end
      end
    end else if (tick) begin
      if (m_state == 1) begin
        m_secs = m_secs - 1;
        if (m_secs == 0) begin m_state = 3; m_done = 1; m_alarm = 0; end
      end else if (m_state == 3) begin
        m_alarm = m_alarm + 1;
        if (m_alarm == AlarmSecs) begin m_state = 0; m_alarm = 0; end
      end
    end
  endtask

  always @(posedge clk_in) begin
    model_step();
    #1;
    if (chk_en) begin
      chk("digits", bus.digits, to_bcd(m_secs));
      chk("state", 16'(bus.state), 16'(m_state));
      chk("mag_on", 16'(bus.mag_on), 16'(m_state == 1));
      chk("buzzer", 16'(bus.buzzer), 16'(m_state == 3));
      chk("done", 16'(bus.done), 16'(m_done));
      chk("load_err", 16'(bus.load_err), 16'(m_err));
    end
  end

  task automatic cyc(input bit ld, input logic [15:0] ldv, input bit st, input bit sp,
                     input bit dr);
    @(negedge clk_in);
    rst_n = rst_v;
    bus.load = ld; bus.ld_digits = ldv; bus.start = st; bus.stop = sp; bus.door_open = dr;
    bus.sec_clk = (sec_force >= 0) ? sec_force[0] : ((cyc_cnt % per) >= per / 2);
    cyc_cnt++;
    @(posedge clk_in);
    #2;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    bit seen100, seen59, got_done, got_idle;
    int r;
    logic [15:0] ldv;

    // Reset with sec_clk high; release must not count as a tick.
    rst_v = 1'b0; sec_force = 1;
    idle(3);
    rst_v = 1'b1;
    idle(3);
    chk("rst_digits", bus.digits, 16'h0000);
    chk("rst_state", 16'(bus.state), 16'h0);
    chk("rst_mag", 16'(bus.mag_on | bus.buzzer | bus.done | bus.load_err), 16'h0);

    // Full countdown from 01:02 through the alarm.
    sec_force = -1; per = 100;
    cyc(1'b1, 16'h0102, 1'b0, 1'b0, 1'b0);
    chk("load_0102", bus.digits, 16'h0102);
    cyc(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
    chk("start_run", 16'(bus.state), 16'h1);
    seen100 = 0; seen59 = 0; got_done = 0;
    for (int i = 0; i < 13000 && !got_done; i++) begin
      idle(1);
      if (bus.digits == 16'h0100) seen100 = 1;
      if (bus.digits == 16'h0059) seen59 = 1;
      if (bus.done) got_done = 1;
    end
    chk("seen_0100", 16'(seen100), 16'h1);
    chk("seen_0059", 16'(seen59), 16'h1);
    chk("done_pulse", 16'(got_done), 16'h1);
    chk("done_buzzer", 16'(bus.buzzer), 16'h1);
    got_idle = 0;
    for (int i = 0; i < 400 && !got_idle; i++) begin
      idle(1);
      if (bus.state == 2'd0) got_idle = 1;
    end
    chk("alarm_to_idle", 16'(got_idle), 16'h1);
    chk("alarm_buzzer_off", 16'(bus.buzzer), 16'h0);

    // Load legality.
    cyc(1'b1, 16'h0070, 1'b0, 1'b0, 1'b0);
    chk("err_0070", 16'(bus.load_err), 16'h1);
    chk("keep_0070", bus.digits, 16'h0000);
    idle(1);
    chk("err_one_cycle", 16'(bus.load_err), 16'h0);
    cyc(1'b1, 16'hA000, 1'b0, 1'b0, 1'b0);
    chk("err_A000", 16'(bus.load_err), 16'h1);
    cyc(1'b1, 16'h9959, 1'b0, 1'b0, 1'b0);
    chk("load_9959", bus.digits, 16'h9959);

    // Door interlock at 00:30.
    sec_force = 0;
    cyc(1'b1, 16'h0030, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
    chk("door_pause", 16'(bus.state), 16'h2);
    chk("door_mag", 16'(bus.mag_on), 16'h0);
    cyc(1'b0, 16'h0, 1'b1, 1'b0, 1'b1);
    chk("door_start_ign", 16'(bus.state), 16'h2);
    cyc(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
    chk("resume_run", 16'(bus.state), 16'h1);
    chk("resume_digits", bus.digits, 16'h0030);
    sec_force = -1; per = 4;
    idle(20);
    chk("resume_count", bus.digits, 16'h0025);

    // Stop beats a same-cycle tick; a second stop clears.
    sec_force = 0;
    cyc(1'b0, 16'h0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 16'h0, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 16'h0010, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
    sec_force = 1;
    cyc(1'b0, 16'h0, 1'b0, 1'b1, 1'b0);
    chk("stop_tick_state", 16'(bus.state), 16'h2);
    chk("stop_tick_digits", bus.digits, 16'h0010);
    sec_force = 0;
    cyc(1'b0, 16'h0, 1'b0, 1'b1, 1'b0);
    chk("stop2_state", 16'(bus.state), 16'h0);
    chk("stop2_digits", bus.digits, 16'h0000);

    // Start at zero, load during run, mid-run reset.
    cyc(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
    chk("start_zero", 16'(bus.state), 16'h0);
    cyc(1'b1, 16'h0005, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 16'h0200, 1'b0, 1'b0, 1'b0);
    chk("run_load_noerr", 16'(bus.load_err), 16'h0);
    chk("run_load_ign", bus.digits, 16'h0005);
    rst_v = 1'b0;
    idle(1);
    rst_v = 1'b1;
    chk("midrun_rst_state", 16'(bus.state), 16'h0);
    chk("midrun_rst_digits", bus.digits, 16'h0000);
    chk("midrun_rst_mag", 16'(bus.mag_on), 16'h0);

    // Randomized traffic against the model.
    sec_force = -1;
    for (int i = 0; i < 4000; i++) begin
      if (i % 200 == 0) per = $urandom_range(2, 12);
      r = $urandom_range(0, 99);
      if ($urandom_range(0, 9) < 7)
        ldv = {4'd0, 4'($urandom_range(0, 1)), 4'($urandom_range(0, 2)),
               4'($urandom_range(0, 9))};
      else
        ldv = 16'($urandom);
      rst_v = ($urandom_range(0, 499) != 0);
      cyc(r < 6, ldv, r >= 6 && r < 16, r >= 16 && r < 19, $urandom_range(0, 49) == 0);
    end
    rst_v = 1'b1;
    idle(2);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
